// File: rtl/lc3b_types.sv
// Shared widths for the LC-3b cache hierarchy: address fields, word and line types.
package lc3b_types;

    typedef logic [8:0]   lc3b_c_tag;
    typedef logic [2:0]   lc3b_c_set;
    typedef logic [3:0]   lc3b_c_offset;
    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    localparam lc3b_word LC3B_LINE_MASK = 16'hFFF0;

    // Physical line base: the offset bits are always zero on the memory side.
    function automatic lc3b_word line_base(lc3b_word addr);
        line_base = addr & LC3B_LINE_MASK;
    endfunction

endpackage

// File: rtl/l2_lru_array.sv
// One LRU bit per set: the stored value names the way to evict next.
module l2_lru_array
    import lc3b_types::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  lc3b_c_set set_i,
    input  logic      we_i,
    input  logic      din_i,
    output logic      victim_o
);

    logic [7:0] lru_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lru_q <= '0;
        end else if (we_i) begin
            lru_q[set_i] <= din_i;
        end
    end

    assign victim_o = lru_q[set_i];

endmodule

// File: rtl/l2_control.sv
// Two-way L2 cache controller: hit/miss handling, victim writeback, line fill and perf counters.
module l2_control
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     mem_read,
    input  logic     mem_write,
    input  lc3b_word mem_address,
    output logic     mem_resp,
    output lc3b_line mem_rdata,
    output logic     pmem_read,
    output logic     pmem_write,
    input  logic     pmem_resp,
    output lc3b_word pmem_address,
    output lc3b_line pmem_wdata,
    input  logic     hit0,
    input  logic     hit1,
    input  logic     dirty0,
    input  logic     dirty1,
    input  lc3b_word addr0,
    input  lc3b_word addr1,
    input  lc3b_line data0,
    input  lc3b_line data1,
    output logic     lru0,
    output logic     lru1,
    output logic     write_back,
    output logic     way_mem_write,
    output logic     src_sel,
    output lc3b_word hit_count,
    output lc3b_word miss_count
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t    state_q, state_d;
    lc3b_word  hit_cnt_q, hit_cnt_d;
    lc3b_word  miss_cnt_q, miss_cnt_d;
    logic      filled_q, filled_d;

    lc3b_c_set set;
    logic      victim;
    logic      lru_we;
    logic      lru_din;
    logic      req;
    logic      any_hit;
    logic      victim_dirty;

    assign set          = mem_address[6:4];
    assign req          = mem_read | mem_write;
    assign any_hit      = hit0 | hit1;
    assign victim_dirty = victim ? dirty1 : dirty0;

    l2_lru_array u_lru (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_i    (set),
        .we_i     (lru_we),
        .din_i    (lru_din),
        .victim_o (victim)
    );

    assign lru0       = ~victim;
    assign lru1       = victim;
    assign mem_rdata  = hit0 ? data0 : data1;
    assign pmem_wdata = victim ? data1 : data0;

    always_comb begin
        state_d       = state_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        filled_d      = filled_q;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        write_back    = 1'b0;
        way_mem_write = 1'b0;
        src_sel       = 1'b0;
        lru_we        = 1'b0;
        lru_din       = hit0;
        pmem_address  = line_base(mem_address);
        case (state_q)
            IDLE: begin
                src_sel = mem_write;
                if (req && any_hit) begin
                    mem_resp      = 1'b1;
                    way_mem_write = mem_write;
                    lru_we        = 1'b1;
                    filled_d      = 1'b0;
                    // The re-evaluation hit that closes a miss is not a fresh hit.
                    if (!filled_q && hit_cnt_q != 16'hFFFF) begin
                        hit_cnt_d = hit_cnt_q + 16'd1;
                    end
                end else if (req) begin
                    if (miss_cnt_q != 16'hFFFF) begin
                        miss_cnt_d = miss_cnt_q + 16'd1;
                    end
                    state_d = victim_dirty ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = line_base(victim ? addr1 : addr0);
                if (pmem_resp) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    write_back = 1'b1;
                    filled_d   = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset abandons any outstanding transaction without touching the ways.
        if (!rst_n) begin
            mem_resp      = 1'b0;
            pmem_read     = 1'b0;
            pmem_write    = 1'b0;
            write_back    = 1'b0;
            way_mem_write = 1'b0;
            lru_we        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            filled_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            filled_q   <= filled_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_l2_control.sv
// Randomized bench for l2_control: behavioural two-way ways, physical memory and a cache-level reference model.
module tb_l2_control;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_read, mem_write;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic         mem_resp;
    logic [127:0] mem_rdata;
    logic         pmem_read, pmem_write, pmem_resp;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         hit0, hit1, dirty0, dirty1;
    logic [15:0]  addr0, addr1;
    logic [127:0] data0, data1;
    logic         lru0, lru1, write_back, way_mem_write, src_sel;
    logic [15:0]  hit_count, miss_count;

    always #5 clk = ~clk;

    l2_control dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .hit0(hit0), .hit1(hit1), .dirty0(dirty0), .dirty1(dirty1),
        .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
        .lru0(lru0), .lru1(lru1), .write_back(write_back),
        .way_mem_write(way_mem_write), .src_sel(src_sel),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    function automatic logic [127:0] init_line(input logic [11:0] ln);
        init_line = {4{4'hC, ln, 4'h3, ~ln}};
    endfunction

    // ---------------- environment: two ways ----------------
    logic [8:0]   w_tag   [2][8];
    logic         w_valid [2][8];
    logic         w_dirty [2][8];
    logic [127:0] w_data  [2][8];
    logic         init_ways;

    always_comb begin
        hit0   = w_valid[0][mem_address[6:4]] && (w_tag[0][mem_address[6:4]] == mem_address[15:7]);
        hit1   = w_valid[1][mem_address[6:4]] && (w_tag[1][mem_address[6:4]] == mem_address[15:7]);
        dirty0 = w_valid[0][mem_address[6:4]] && w_dirty[0][mem_address[6:4]] && lru0;
        dirty1 = w_valid[1][mem_address[6:4]] && w_dirty[1][mem_address[6:4]] && lru1;
        addr0  = {w_tag[0][mem_address[6:4]], mem_address[6:4], 4'b0};
        addr1  = {w_tag[1][mem_address[6:4]], mem_address[6:4], 4'b0};
        data0  = w_data[0][mem_address[6:4]];
        data1  = w_data[1][mem_address[6:4]];
    end

    always @(posedge clk) begin
        for (int w = 0; w < 2; w++) begin
            logic [2:0] s;
            logic       sel, hw;
            s   = mem_address[6:4];
            sel = (w == 0) ? lru0 : lru1;
            hw  = (w == 0) ? hit0 : hit1;
            if (init_ways) begin
                for (int k = 0; k < 8; k++) begin
                    w_valid[w][k] <= 1'b0;
                    w_dirty[w][k] <= 1'b0;
                    w_tag[w][k]   <= '0;
                    w_data[w][k]  <= '0;
                end
            end else if (write_back && sel) begin
                w_tag[w][s]   <= mem_address[15:7];
                w_valid[w][s] <= 1'b1;
                w_dirty[w][s] <= 1'b0;
                w_data[w][s]  <= src_sel ? mem_wdata : pmem_rdata;
            end else if (way_mem_write && hw) begin
                w_data[w][s]  <= src_sel ? mem_wdata : pmem_rdata;
                w_dirty[w][s] <= 1'b1;
            end
        end
    end

    // ---------------- environment: physical memory ----------------
    typedef struct {
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] data;
    } op_t;

    op_t          opq[$];
    logic [127:0] pmem [4096];
    logic         resp_r, inject_resp, resp_block;
    int           excl_cnt = 0;

    assign pmem_resp = resp_r | inject_resp;

    initial begin
        int lat;
        lat = 0;
        resp_r = 1'b0;
        pmem_rdata = '0;
        for (int i = 0; i < 4096; i++) pmem[i] = init_line(i[11:0]);
        forever begin
            @(posedge clk);
            #2;
            if (pmem_read && pmem_write) excl_cnt++;
            if (resp_r || resp_block) begin
                resp_r = 1'b0;
                lat = 0;
            end else if (pmem_read || pmem_write) begin
                if (lat == 0) lat = $urandom_range(1, 4);
                lat--;
                if (lat == 0) begin
                    resp_r = 1'b1;
                    if (pmem_write) begin
                        pmem[pmem_address[15:4]] = pmem_wdata;
                        opq.push_back('{1'b1, pmem_address, pmem_wdata});
                    end else begin
                        pmem_rdata = pmem[pmem_address[15:4]];
                        opq.push_back('{1'b0, pmem_address, 128'h0});
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [8:0]   m_tag   [2][8];
    bit           m_valid [2][8];
    bit           m_dirty [2][8];
    logic [127:0] m_data  [2][8];
    bit           m_lru   [8];
    logic [127:0] ref_mem [4096];
    int           exp_hits = 0;
    int           exp_miss = 0;
    int           txn_no = 0;

    task automatic do_txn(input logic [15:0] a, input bit wr, input logic [127:0] wd);
        logic [2:0]   s;
        logic [11:0]  vline;
        int           hitw, v, cycles;
        bit           exp_hit, got;
        logic [127:0] exp_rdata, seen_rdata;
        op_t          exp_ops[$];

        s = a[6:4];
        hitw = -1;
        for (int w = 1; w >= 0; w--)
            if (m_valid[w][s] && m_tag[w][s] == a[15:7]) hitw = w;
        v = int'(m_lru[s]);
        exp_hit = (hitw >= 0);
        if (!exp_hit) begin
            if (exp_miss < 65535) exp_miss++;
            if (m_valid[v][s] && m_dirty[v][s]) begin
                vline = {m_tag[v][s], s};
                exp_ops.push_back('{1'b1, {vline, 4'b0}, m_data[v][s]});
                ref_mem[vline] = m_data[v][s];
            end
            exp_ops.push_back('{1'b0, {a[15:4], 4'b0}, 128'h0});
            m_tag[v][s]   = a[15:7];
            m_valid[v][s] = 1'b1;
            m_dirty[v][s] = 1'b0;
            m_data[v][s]  = ref_mem[a[15:4]];
            hitw = v;
        end else if (exp_hits < 65535) begin
            exp_hits++;
        end
        exp_rdata = m_data[hitw][s];
        if (wr) begin
            m_data[hitw][s]  = wd;
            m_dirty[hitw][s] = 1'b1;
        end
        m_lru[s] = (hitw == 0);

        opq.delete();
        mem_address = a;
        mem_write   = wr;
        mem_read    = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_wdata   = wd;
        cycles = 0;
        got = 1'b0;
        seen_rdata = '0;
        while (!got && cycles < 100) begin
            @(negedge clk);
            if (cycles == 0) check_val("victim_sel", {lru1, lru0}, {v[0], ~v[0]});
            if (mem_resp) begin
                got = 1'b1;
                seen_rdata = mem_rdata;
            end else begin
                cycles++;
            end
        end
        if (!got) begin
            check_val("resp_timeout", 1'b0, 1'b1);
            finish_run();
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        check_val("hit_latency", cycles == 0, exp_hit);
        check_val("pmem_ops", opq.size(), exp_ops.size());
        for (int i = 0; i < exp_ops.size() && i < opq.size(); i++) begin
            check_val("op_kind", opq[i].wr, exp_ops[i].wr);
            check_val("op_addr", opq[i].addr, exp_ops[i].addr);
            if (exp_ops[i].wr) check_val("op_wdata", opq[i].data, exp_ops[i].data);
        end
        if (!wr) check_val("rdata", seen_rdata, exp_rdata);
        check_val("hit_count", hit_count, exp_hits);
        check_val("miss_count", miss_count, exp_miss);
        check_val("pmem_excl", excl_cnt, 0);
        $display("txn %0d addr=%h wr=%0d hit=%0d cycles=%0d ops=%0d hits=%0d misses=%0d",
                 txn_no, a, wr, exp_hit, cycles, opq.size(), hit_count, miss_count);
        txn_no++;
    endtask

    function automatic logic [127:0] rnd_line();
        rnd_line = {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic reset_model();
        exp_hits = 0;
        exp_miss = 0;
        for (int k = 0; k < 8; k++) m_lru[k] = 1'b0;
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        init_ways = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_address = '0;
        mem_wdata = '0;
        inject_resp = 1'b0;
        resp_block = 1'b0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_line(i[11:0]);
        for (int w = 0; w < 2; w++)
            for (int k = 0; k < 8; k++) begin
                m_valid[w][k] = 1'b0;
                m_dirty[w][k] = 1'b0;
                m_tag[w][k]   = '0;
                m_data[w][k]  = '0;
            end
        reset_model();

        repeat (2) @(posedge clk);
        mem_read = 1'b1;
        @(negedge clk);
        check_val("rst_strobes", {mem_resp, pmem_read, pmem_write, write_back, way_mem_write}, 5'b0);
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        rst_n = 1'b1;
        init_ways = 1'b0;
        check_val("rst_counters", {hit_count, miss_count}, 32'h0);

        do_txn(16'h1230, 1'b0, '0);
        do_txn(16'h1230, 1'b0, '0);
        do_txn(16'h4560, 1'b1, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C);
        do_txn(16'h4560, 1'b0, '0);
        do_txn(16'h0030, 1'b1, 128'h0030_0030_0030_0030_0030_0030_0030_0030);
        do_txn(16'h2030, 1'b0, '0);
        do_txn(16'h4030, 1'b0, '0);
        do_txn(16'h0050, 1'b0, '0);
        do_txn(16'h0050, 1'b0, '0);
        do_txn(16'h0250, 1'b0, '0);
        do_txn(16'h0050, 1'b0, '0);

        // Stray pmem_resp while idle must be ignored.
        mem_address = 16'h1230;
        inject_resp = 1'b1;
        @(negedge clk);
        check_val("idle_resp_strobes", {mem_resp, pmem_read, pmem_write, write_back, way_mem_write}, 5'b0);
        @(posedge clk);
        #1;
        inject_resp = 1'b0;
        @(negedge clk);
        check_val("idle_resp_state", {pmem_read, pmem_write, hit_count, miss_count},
                  {2'b00, exp_hits[15:0], exp_miss[15:0]});

        // Reset in the middle of a fill.
        resp_block = 1'b1;
        @(posedge clk);
        #1;
        mem_address = 16'h4070;
        mem_read = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!pmem_read && cyc < 20);
        check_val("fill_seen", pmem_read, 1'b1);
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_val("rst_fill_strobes", {mem_resp, pmem_read, pmem_write, write_back, way_mem_write}, 5'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_model();
        @(negedge clk);
        check_val("post_rst_idle", {pmem_read, pmem_write, write_back, hit_count, miss_count}, 35'h0);
        resp_block = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            a = {9'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            do_txn(a, $urandom_range(0, 2) == 0, rnd_line());
        end
        finish_run();
    end

endmodule
